// File: rtl/mem_bus_pkg.sv
// Shared constants for the CPU-to-SRAM halfword bus bridge.
// FSM encodings and bus level names used by sram_bridge.
package mem_bus_pkg;

    localparam int HALF_W = 16;

    localparam logic ACTIVE_LO   = 1'b0;
    localparam logic INACTIVE_HI = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/sram_bridge.sv
// CPU word port to 16-bit asynchronous SRAM bridge.
// Splits each word into halfword beats with programmable wait states.
module sram_bridge
    import mem_bus_pkg::*;
#(
    parameter int CPU_DW      = 32,
    parameter int ADDR_W      = 18,
    parameter int WAIT_STATES = 1,
    localparam int BEATS = CPU_DW / HALF_W,
    localparam int LB    = $clog2(BEATS),
    localparam int BW    = (LB > 0) ? LB : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-LB-1:0]  cpu_addr,
    input  logic [CPU_DW-1:0]     cpu_wdata,
    input  logic [CPU_DW/8-1:0]   cpu_be,
    output logic [CPU_DW-1:0]     cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_busy,
    output logic [ADDR_W-1:0]     addr,
    inout  wire  [HALF_W-1:0]     data,
    output logic                  wre,
    output logic                  oute,
    output logic                  hb_mask,
    output logic                  lb_mask,
    output logic                  chip_en
);

    logic [2:0]           state_q;
    logic                 we_q;
    logic [ADDR_W-LB-1:0] addr_q;
    logic [CPU_DW-1:0]    wdata_q;
    logic [CPU_DW/8-1:0]  be_q;
    logic [BW-1:0]        beat_q;
    logic [3:0]           cnt_q;

    logic [BEATS-1:0] en_in;
    logic [BEATS-1:0] en_q;
    logic [BEATS-1:0] cand;
    logic             nxt_ok;
    logic [BW-1:0]    nxt_b;
    logic [HALF_W-1:0] wr_half;
    logic [1:0]       be_pair;
    logic             in_beat;
    logic             drive_en;

    // A beat is needed for every read, and for writes with a live lane
    for (genvar g = 0; g < BEATS; g++) begin : g_en
        assign en_in[g] = !cpu_we || cpu_be[2*g] || cpu_be[2*g+1];
        assign en_q[g]  = !we_q || be_q[2*g] || be_q[2*g+1];
        assign cand[g]  = (state_q == S_IDLE) ? en_in[g]
                        : (en_q[g] && (BW'(g) > beat_q));
    end

    always_comb begin
        nxt_ok = |cand;
        nxt_b  = '0;
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (cand[i]) nxt_b = BW'(i);
        end
    end

    always_comb begin
        wr_half = '0;
        be_pair = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BW'(i)) begin
                wr_half = wdata_q[i*HALF_W +: HALF_W];
                be_pair = be_q[2*i +: 2];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            cpu_rdata <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        we_q    <= cpu_we;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        be_q    <= cpu_be;
                        beat_q  <= nxt_b;
                        state_q <= nxt_ok ? S_SETUP : S_DONE;
                    end
                end
                S_SETUP: begin
                    cnt_q   <= '0;
                    state_q <= S_STROBE;
                end
                S_STROBE: begin
                    if (cnt_q == 4'(WAIT_STATES)) begin
                        state_q <= S_HOLD;
                        for (int i = 0; i < BEATS; i++) begin
                            if (!we_q && beat_q == BW'(i))
                                cpu_rdata[i*HALF_W +: HALF_W] <= data;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (nxt_ok) begin
                        beat_q  <= nxt_b;
                        state_q <= S_SETUP;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_beat  = (state_q == S_SETUP) || (state_q == S_STROBE)
                   || (state_q == S_HOLD);
    assign drive_en = in_beat && we_q;

    assign chip_en = in_beat ? ACTIVE_LO : INACTIVE_HI;
    assign wre  = (state_q == S_STROBE && we_q)  ? ACTIVE_LO : INACTIVE_HI;
    assign oute = (state_q == S_STROBE && !we_q) ? ACTIVE_LO : INACTIVE_HI;

    assign hb_mask = !in_beat ? INACTIVE_HI
                   : (we_q ? ~be_pair[1] : ACTIVE_LO);
    assign lb_mask = !in_beat ? INACTIVE_HI
                   : (we_q ? ~be_pair[0] : ACTIVE_LO);

    assign addr = in_beat
                ? ((ADDR_W'(addr_q) << LB) | ADDR_W'(beat_q))
                : '0;

    assign data = drive_en ? wr_half : 16'hzzzz;

    assign cpu_ready = (state_q == S_DONE);
    assign cpu_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_bridge.sv
// Bench for sram_bridge: 32-bit/1-wait and 64-bit/0-wait instances
// against a behavioural SRAM and a byte-level reference memory.
module tb_sram_bridge;

    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [16:0] caddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        ready, busy;
    logic [17:0] sa;
    wire  [15:0] sd;
    logic        wre, oute, hb, lb, ce;

    logic [15:0] mem [0:1023];
    logic [15:0] ref_mem [0:1023];

    sram_bridge #(.CPU_DW(32), .ADDR_W(18), .WAIT_STATES(WS)) dut (
        .clock(clk), .reset(rst_n),
        .cpu_req(req), .cpu_we(we), .cpu_addr(caddr),
        .cpu_wdata(wdata), .cpu_be(be),
        .cpu_rdata(rdata), .cpu_ready(ready), .cpu_busy(busy),
        .addr(sa), .data(sd), .wre(wre), .oute(oute),
        .hb_mask(hb), .lb_mask(lb), .chip_en(ce)
    );

    assign sd = (!ce && !oute) ? mem[sa[9:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!ce && !wre) begin
            if (!lb) mem[sa[9:0]][7:0]  <= sd[7:0];
            if (!hb) mem[sa[9:0]][15:8] <= sd[15:8];
        end
    end

    logic        req64 = 1'b0;
    logic [7:0]  caddr64 = '0;
    logic [63:0] rdata64;
    logic        ready64, busy64;
    logic [9:0]  sa64;
    wire  [15:0] sd64;
    logic        wre64, oute64, hb64, lb64, ce64;

    sram_bridge #(.CPU_DW(64), .ADDR_W(10), .WAIT_STATES(0)) dut64 (
        .clock(clk), .reset(rst_n),
        .cpu_req(req64), .cpu_we(1'b0), .cpu_addr(caddr64),
        .cpu_wdata(64'h0), .cpu_be(8'hFF),
        .cpu_rdata(rdata64), .cpu_ready(ready64), .cpu_busy(busy64),
        .addr(sa64), .data(sd64), .wre(wre64), .oute(oute64),
        .hb_mask(hb64), .lb_mask(lb64), .chip_en(ce64)
    );

    function automatic logic [15:0] pat64(input int i);
        return 16'(i * 16'h1357) ^ 16'hA5A5;
    endfunction

    assign sd64 = (!ce64 && !oute64) ? pat64(int'(sa64)) : 16'hzzzz;

    typedef struct packed {
        logic [17:0] a;
        logic        h;
        logic        l;
        logic        w;
        logic [15:0] d;
    } strobe_t;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ref_write(input logic [16:0] a_i, input logic [31:0] d_i,
                             input logic [3:0] b_i);
        int hw;
        for (int i = 0; i < 4; i++) begin
            if (b_i[i]) begin
                hw = 2 * int'(a_i) + i / 2;
                if (i % 2 == 1) ref_mem[hw][15:8] = d_i[8*i +: 8];
                else            ref_mem[hw][7:0]  = d_i[8*i +: 8];
            end
        end
    endtask

    task automatic do_access(input logic w_i, input logic [16:0] a_i,
                             input logic [31:0] d_i, input logic [3:0] b_i,
                             output logic [31:0] rd_o, output int lat_o);
        strobe_t q[$];
        int cyc, nb, k, lo;
        logic en;
        @(posedge clk); #1;
        req = 1'b1; we = w_i; caddr = a_i; wdata = d_i; be = b_i;
        @(posedge clk); #1;
        req = 1'b0;
        cyc = 1;
        check("busy_after_accept", busy, 1);
        forever begin
            @(negedge clk);
            check("strobe_overlap", !wre && !oute, 0);
            check("drive_on_read", dut.drive_en && !oute, 0);
            if (!wre || !oute) q.push_back('{sa, hb, lb, !wre, sd});
            if (ready || cyc >= 100) break;
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_seen", ready, 1);
        rd_o = rdata;
        lat_o = cyc;
        nb = 0;
        k = 0;
        for (int b = 0; b < 2; b++) begin
            en = !w_i || b_i[2*b] || b_i[2*b+1];
            if (!en) continue;
            nb++;
            for (int s = 0; s <= WS; s++) begin
                if (k < q.size()) begin
                    check("beat_addr", q[k].a, {a_i, b[0]});
                    check("beat_kind", q[k].w, w_i);
                    check("hb_mask", q[k].h, w_i ? !b_i[2*b+1] : 1'b0);
                    check("lb_mask", q[k].l, w_i ? !b_i[2*b] : 1'b0);
                    if (w_i) check("wr_half", q[k].d, d_i[16*b +: 16]);
                end
                k++;
            end
        end
        check("strobe_cycles", q.size(), nb * (WS + 1));
        check("latency", cyc, nb * (WS + 3) + 1);
        lo = 2 * int'(a_i);
        if (!w_i) check("rdata", rdata, {ref_mem[lo+1], ref_mem[lo]});
        else      ref_write(a_i, d_i, b_i);
        @(posedge clk); #1;
        check("busy_after_ready", busy, 0);
        if (w_i) begin
            check("sram_lo", mem[lo], ref_mem[lo]);
            check("sram_hi", mem[lo+1], ref_mem[lo+1]);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] v;
        int lat, cyc;
        strobe_t q64[$];

        for (int i = 0; i < 1024; i++) begin
            v = 16'($urandom);
            if (i == 29) v = 16'h4820;
            ref_mem[i] = v;
            mem[i] <= v;
        end

        // Reset with a pending request
        req = 1'b1; we = 1'b0; caddr = 17'h00E; be = 4'hF;
        #1 rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_ce", ce, 1);
            check("rst_wre", wre, 1);
            check("rst_oute", oute, 1);
            check("rst_masks", {hb, lb}, 2'b11);
            check("rst_addr", sa, 0);
            check("rst_drive", dut.drive_en, 0);
            check("rst_busy", busy, 0);
            check("rst_ready", ready, 0);
            check("rst_rdata", rdata, 0);
        end
        req = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed read of halfwords 28/29
        do_access(1'b0, 17'h00E, 32'h0, 4'hF, rd, lat);
        check("rd_latency9", lat, 9);
        check("rd_upper", rd[31:16], 16'h4820);

        // Single-byte write into beat 1, then read it back
        do_access(1'b1, 17'h00E, 32'hDEADBEEF, 4'b0100, rd, lat);
        check("wr_latency5", lat, 5);
        do_access(1'b0, 17'h00E, 32'h0, 4'hF, rd, lat);
        check("rb_upper", rd[31:16], 16'h48AD);

        // Empty write with req held high, then back-to-back read
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; be = 4'h0; caddr = 17'd5;
        @(posedge clk); #1;
        check("be0_ready", ready, 1);
        check("be0_busy", busy, 1);
        check("be0_ce", ce, 1);
        we = 1'b0; be = 4'hF; caddr = 17'd14;
        @(posedge clk); #1;
        check("be0_idle_busy", busy, 0);
        check("be0_idle_ce", ce, 1);
        @(posedge clk); #1;
        check("b2b_busy", busy, 1);
        check("b2b_ce", ce, 0);
        req = 1'b0;
        cyc = 3;
        while (!ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_latency", cyc, 11);
        check("b2b_rdata", rdata, {ref_mem[29], ref_mem[28]});

        // Reset in the middle of a write strobe
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; caddr = 17'd20;
        wdata = $urandom; be = 4'hF;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("mid_wre_low", wre, 0);
        rst_n = 1'b0;
        #1;
        check("mid_wre", wre, 1);
        check("mid_ce", ce, 1);
        check("mid_drive", dut.drive_en, 0);
        check("mid_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_sram_lo", mem[40], ref_mem[40]);
        check("mid_sram_hi", mem[41], ref_mem[41]);

        // Randomised accesses
        for (int t = 0; t < 24; t++) begin
            do_access(1'($urandom), 17'($urandom_range(0, 63)),
                      $urandom, 4'($urandom), rd, lat);
        end

        // Four-beat read with no wait states
        @(posedge clk); #1;
        req64 = 1'b1; caddr64 = 8'd3;
        @(posedge clk); #1;
        req64 = 1'b0;
        cyc = 1;
        forever begin
            @(negedge clk);
            if (!oute64) q64.push_back('{18'(sa64), hb64, lb64, 1'b0, sd64});
            if (ready64 || cyc >= 100) break;
            @(posedge clk); #1;
            cyc++;
        end
        check("w64_ready", ready64, 1);
        check("w64_latency", cyc, 13);
        check("w64_strobes", q64.size(), 4);
        for (int b = 0; b < 4; b++) begin
            if (b < q64.size()) check("w64_addr", q64[b].a, 12 + b);
            check("w64_rdata", rdata64[16*b +: 16], pat64(12 + b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
